// File: rtl/hack_mem_pkg.sv
// hack_mem_pkg: Hack data-memory address map, region decode and scan-out FSM types.
// Shared by hack_memory and hack_screen_scan.
package hack_mem_pkg;

   localparam logic [14:0] RAM_BASE     = 15'h0000;
   localparam logic [14:0] SCREEN_BASE  = 15'h4000;
   localparam logic [14:0] KBD_ADDR     = 15'h6000;
   localparam int unsigned RAM_WORDS    = 16384;
   localparam int unsigned SCREEN_WORDS = 8192;
   localparam int unsigned RAM_AW       = 14;
   localparam int unsigned SCREEN_AW    = 13;

   typedef enum logic [1:0] {RAM, SCREEN, KBD, NONE} mem_region_t;
   typedef enum logic {IDLE, STREAM} scan_state_t;

   function automatic mem_region_t decode_region(input logic [14:0] addr);
      if (addr < SCREEN_BASE)
         return RAM;
      else if (addr < KBD_ADDR)
         return SCREEN;
      else if (addr == KBD_ADDR)
         return KBD;
      else
         return NONE;
   endfunction

endpackage

// File: rtl/hack_screen_scan.sv
// hack_screen_scan: raster scan-out of the screen buffer as a 1-bit pixel stream
// with valid/ready handshake; reads screen words through a combinational port.
module hack_screen_scan
   import hack_mem_pkg::*;
#(
   parameter int unsigned SCREEN_ROWS = 256,
   parameter int unsigned ROW_WORDS   = 32
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   output logic [SCREEN_AW-1:0] o_rd_addr,
   input  logic [15:0]          i_rd_data,
   input  logic                 i_ready,
   output logic                 o_pix,
   output logic                 o_valid,
   output logic                 o_sof,
   output logic                 o_eol
);

   localparam int unsigned RW = (SCREEN_ROWS > 1) ? $clog2(SCREEN_ROWS) : 1;
   localparam int unsigned WW = (ROW_WORDS > 1) ? $clog2(ROW_WORDS) : 1;
   localparam logic [RW-1:0] LAST_ROW  = RW'(SCREEN_ROWS - 1);
   localparam logic [WW-1:0] LAST_WORD = WW'(ROW_WORDS - 1);

   scan_state_t   r_state;
   scan_state_t   w_state_nxt;
   logic [RW-1:0] r_row;
   logic [RW-1:0] w_row_nxt;
   logic [WW-1:0] r_word;
   logic [WW-1:0] w_word_nxt;
   logic [3:0]    r_bit;
   logic [15:0]   r_shift;
   logic          r_loaded;
   logic          w_accept;
   logic          w_load;

   // Position of the word that follows the current one; it is also the word fetched on a load.
   always_comb begin
      w_word_nxt = r_word + WW'(1);
      w_row_nxt  = r_row;
      if (r_word == LAST_WORD) begin
         w_word_nxt = '0;
         w_row_nxt  = (r_row == LAST_ROW) ? '0 : r_row + RW'(1);
      end
   end

   assign o_rd_addr = (r_state == IDLE) ? '0
                    : SCREEN_AW'(32'(w_row_nxt) * ROW_WORDS + 32'(w_word_nxt));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_state <= IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_load      = 1'b0;
      o_valid     = 1'b0;
      case (r_state)
         IDLE: begin
            w_state_nxt = STREAM;
            w_load      = 1'b1;
         end
         STREAM: begin
            o_valid  = r_loaded;
            w_accept = r_loaded & i_ready;
            w_load   = w_accept & (r_bit == 4'd15);
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_row    <= '0;
         r_word   <= '0;
         r_bit    <= '0;
         r_shift  <= '0;
         r_loaded <= 1'b0;
      end else begin
         if (w_load) begin
            r_shift  <= i_rd_data;
            r_loaded <= 1'b1;
         end else if (w_accept) begin
            r_shift <= {1'b0, r_shift[15:1]};
         end
         if (w_accept) begin
            r_bit <= r_bit + 4'd1;
            if (r_bit == 4'd15) begin
               r_word <= w_word_nxt;
               r_row  <= w_row_nxt;
            end
         end
      end
   end

   assign o_pix = r_shift[0];
   assign o_sof = o_valid & (r_row == '0) & (r_word == '0) & (r_bit == 4'd0);
   assign o_eol = o_valid & (r_word == LAST_WORD) & (r_bit == 4'd15);

endmodule

// File: rtl/hack_memory.sv
// hack_memory: Hack CPU data memory (16K RAM, 8K screen, keyboard register).
// Raster scan-out of the screen is built only when HACK_MEMORY_SCAN_EN is defined.
module hack_memory
   import hack_mem_pkg::*;
#(
   parameter int unsigned SCREEN_ROWS = 256,
   parameter int unsigned ROW_WORDS   = 32
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [14:0] addressM,
   input  logic        writeM,
   input  logic [15:0] outM,
   output logic [15:0] inM,
   input  logic [15:0] kbd_code,
   input  logic        kbd_valid,
   output logic        pix,
   output logic        pix_valid,
   input  logic        pix_ready,
   output logic        pix_sof,
   output logic        pix_eol
);

   logic [15:0]          r_ram    [RAM_WORDS];
   logic [15:0]          r_screen [SCREEN_WORDS];
   logic [15:0]          r_kbd;
   mem_region_t          w_region;
   logic [RAM_AW-1:0]    w_ram_idx;
   logic [SCREEN_AW-1:0] w_scr_idx;

   assign w_region  = decode_region(addressM);
   assign w_ram_idx = RAM_AW'(addressM - RAM_BASE);
   assign w_scr_idx = SCREEN_AW'(addressM - SCREEN_BASE);

   // Memory contents are intentionally not reset.
   always_ff @(posedge clk) begin
      if (writeM) begin
         if (w_region == RAM)
            r_ram[w_ram_idx] <= outM;
         if (w_region == SCREEN)
            r_screen[w_scr_idx] <= outM;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_kbd <= '0;
      else if (kbd_valid)
         r_kbd <= kbd_code;
   end

   always_comb begin
      inM = '0;
      case (w_region)
         RAM:     inM = r_ram[w_ram_idx];
         SCREEN:  inM = r_screen[w_scr_idx];
         KBD:     inM = r_kbd;
         default: inM = '0;
      endcase
   end

`ifdef HACK_MEMORY_SCAN_EN
   logic [SCREEN_AW-1:0] w_scan_addr;
   logic [15:0]          w_scan_data;

   // Read before the CPU write lands, so a same-edge collision streams the old word.
   assign w_scan_data = r_screen[w_scan_addr];

   hack_screen_scan #(
      .SCREEN_ROWS(SCREEN_ROWS),
      .ROW_WORDS  (ROW_WORDS)
   ) u_scan (
      .i_clk    (clk),
      .i_rst_n  (reset_n),
      .o_rd_addr(w_scan_addr),
      .i_rd_data(w_scan_data),
      .i_ready  (pix_ready),
      .o_pix    (pix),
      .o_valid  (pix_valid),
      .o_sof    (pix_sof),
      .o_eol    (pix_eol)
   );
`else
   logic [64:0] w_unused_scan;
   assign w_unused_scan = {pix_ready, 32'(SCREEN_ROWS), 32'(ROW_WORDS)};
   assign pix       = 1'b0;
   assign pix_valid = 1'b0;
   assign pix_sof   = 1'b0;
   assign pix_eol   = 1'b0;
`endif

endmodule
